level_sensor_conditioner: RTL and testbench
===========================================

Name: level_sensor_conditioner

Overview:
- Upstream conditioning stage for the pump-control FSM, placed between the raw tank sensors I (lower) and S (upper) and the FSM's level_sensors input.
- Synchronizes and debounces each sensor, and detects the physically impossible combination S=1, I=0.
- Drives the FSM with a safe "tank full" code (pumps off) while not yet valid or in fault.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles a new sensor value must hold before it is accepted; legal range 2 or more.
- FAULT_CYCLES, 8: consecutive cycles the filtered code must equal 2'b10 before a fault is raised; legal range 1 or more.

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- raw_sensors  input  2  asynchronous field inputs; bit0 = I, bit1 = S
- fault_clear  input  1  operator acknowledge; honoured only in FAULT
- level_sensors  output  2  conditioned code to the pump FSM; bit0 = I, bit1 = S
- sensors_valid  output  1  high only in RUN
- fault  output  1  high only in FAULT
- change_pulse  output  1  one-cycle pulse when level_sensors changes in RUN

Behaviour:
- All outputs are registered. Reset values: level_sensors=2'b11, sensors_valid=0, fault=0, change_pulse=0.
- Reset is synchronous and overrides all other activity in any state. On reset, all counters and synchronizer flops clear to 0 and the state goes to INIT.
- Synchronizer: each raw bit passes through a 2-flop synchronizer to produce sync[1:0].
- Debounce, per bit and independent: a counter of width max(1, clog2(DEBOUNCE_CYCLES)).
  - If sync != filt: the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync still differs: filt <= sync and the counter clears.
  - If sync == filt: the counter clears.
  - Latency: a raw step held steady appears on level_sensors at clock edge DEBOUNCE_CYCLES+2, counting the first edge that samples it as edge 1.
  - A raw pulse shorter than DEBOUNCE_CYCLES cycles is suppressed.
  - Both bits changing in the same cycle are handled independently.
- INIT state:
  - Outputs: level_sensors=2'b11, sensors_valid=0.
  - A stability counter increments while sync equals its previous-cycle value and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1: filt <= sync, then go to RUN. No change_pulse on this transition.
- RUN state:
  - Outputs: level_sensors=filt, sensors_valid=1.
  - change_pulse=1 for exactly the cycle in which level_sensors first shows a new filt value.
  - A fault counter increments while filt==2'b10 and clears otherwise.
  - When the fault counter reaches FAULT_CYCLES-1 with filt still 2'b10: go to FAULT.
- FAULT state:
  - Outputs: fault=1, sensors_valid=0, level_sensors forced to 2'b11, change_pulse=0. Debounce continues internally.
  - Exit to INIT only when fault_clear=1 and filt != 2'b10 in the same cycle; otherwise the fault is sticky.
  - fault_clear is ignored in INIT and RUN.
- State encoding: INIT=2'd0, RUN=2'd1, FAULT=2'd2. Illegal code 3 returns to INIT on the next edge with safe outputs.
- Reset asserted mid-debounce or mid-fault-count discards all partial counts.

Decomposition:
- Shared package holds:
  - state constants ST_INIT, ST_RUN, ST_FAULT
  - bit indices SENSOR_I=0, SENSOR_S=1
  - SAFE_LEVEL=2'b11 and FAULT_CODE=2'b10
- Sub-module sensor_debounce (ports clock, reset, raw, sync, filt, load, load_value), instantiated twice. It contains the 2-flop synchronizer and the per-bit counter.
- The top level holds the state machine, the fault counter, and the output registers.

Test Plan:
- Reset, then hold raw=2'b01 → INIT for 2+4 edges, then sensors_valid=1, level_sensors=2'b01, no change_pulse.
- In RUN with level=2'b01, step raw to 2'b11 → level_sensors=2'b11 exactly 6 edges later, change_pulse high for exactly that one cycle.
- In RUN with level=2'b00, apply a 3-cycle pulse raw=2'b01 → level_sensors stays 2'b00 and change_pulse never asserts. A 4-cycle pulse does update.
- Hold raw=2'b10 → filt=2'b10 after the debounce delay, then fault=1 after 8 further edges. level_sensors=2'b11 and sensors_valid=0 while in fault.
- In FAULT, pulse fault_clear with raw still 2'b10 → stays in FAULT. Set raw=2'b11, wait for debounce, pulse fault_clear → back to INIT, then RUN.
- Assert reset mid-debounce (2 cycles into a change) and mid-fault-count → all outputs return to reset values the next edge, and the state is INIT.

Source files
------------

// File: rtl/level_sensor_conditioner_pkg.sv
// Shared types and constants for the tank level sensor conditioning path.
// Bit order of every 2-bit sensor code: bit0 = I (lower), bit1 = S (upper).
package level_sensor_conditioner_pkg;

    localparam int unsigned SENSOR_W = 2;
    localparam int unsigned SENSOR_I = 0;
    localparam int unsigned SENSOR_S = 1;

    // Code that keeps the pumps off.
    localparam logic [SENSOR_W-1:0] SAFE_LEVEL = 2'b11;
    // S=1 with I=0 cannot happen physically.
    localparam logic [SENSOR_W-1:0] FAULT_CODE = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/level_sensor_conditioner_sensor_debounce.sv
// One sensor bit: 2-flop synchronizer followed by a hold-time debounce filter.
// filt_next exposes the value filt takes at the next edge so the caller can register it in step.
module sensor_debounce
    import level_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic load,
    input  logic load_value,
    output logic sync,
    output logic filt,
    output logic filt_next
);

    localparam int unsigned        CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            filt <= filt_next;
            cnt  <= cnt_next;
        end
    end

    // Accept a new value only after it has differed from filt for DEBOUNCE_CYCLES cycles.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        if (load) begin
            filt_next = load_value;
        end else if (sync != filt) begin
            if (cnt == CNT_MAX) begin
                filt_next = sync;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/level_sensor_conditioner.sv
// Conditions raw I/S tank sensors for the pump FSM: debounce, impossible-combination
// fault detection, and a pumps-off code whenever the readings are not trustworthy.
module level_sensor_conditioner
    import level_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FAULT_CYCLES    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SENSOR_W-1:0] raw_sensors,
    input  logic                fault_clear,
    output logic [SENSOR_W-1:0] level_sensors,
    output logic                sensors_valid,
    output logic                fault,
    output logic                change_pulse
);

    localparam int unsigned       STAB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned       FLT_W    = cnt_width(FAULT_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FLT_W-1:0]  FLT_MAX  = FLT_W'(FAULT_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [SENSOR_W-1:0] sync;
    logic [SENSOR_W-1:0] prev_sync;
    logic [SENSOR_W-1:0] filt;
    logic [SENSOR_W-1:0] filt_next;
    logic                load;
    logic [STAB_W-1:0]   stab_cnt;
    logic [STAB_W-1:0]   stab_cnt_next;
    logic [FLT_W-1:0]    flt_cnt;
    logic [FLT_W-1:0]    flt_cnt_next;
    logic [SENSOR_W-1:0] level_next;
    logic                valid_next;
    logic                fault_next;
    logic                change_next;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_i (
        .clock      (clock),
        .reset      (reset),
        .raw        (raw_sensors[SENSOR_I]),
        .load       (load),
        .load_value (sync[SENSOR_I]),
        .sync       (sync[SENSOR_I]),
        .filt       (filt[SENSOR_I]),
        .filt_next  (filt_next[SENSOR_I])
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_s (
        .clock      (clock),
        .reset      (reset),
        .raw        (raw_sensors[SENSOR_S]),
        .load       (load),
        .load_value (sync[SENSOR_S]),
        .sync       (sync[SENSOR_S]),
        .filt       (filt[SENSOR_S]),
        .filt_next  (filt_next[SENSOR_S])
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_INIT;
            prev_sync     <= '0;
            stab_cnt      <= '0;
            flt_cnt       <= '0;
            level_sensors <= SAFE_LEVEL;
            sensors_valid <= 1'b0;
            fault         <= 1'b0;
            change_pulse  <= 1'b0;
        end else begin
            state         <= state_next;
            prev_sync     <= sync;
            stab_cnt      <= stab_cnt_next;
            flt_cnt       <= flt_cnt_next;
            level_sensors <= level_next;
            sensors_valid <= valid_next;
            fault         <= fault_next;
            change_pulse  <= change_next;
        end
    end

    // Next state and next output values; anything unmatched falls back to INIT with safe outputs.
    always_comb begin
        state_next    = ST_INIT;
        load          = 1'b0;
        stab_cnt_next = '0;
        flt_cnt_next  = '0;
        level_next    = SAFE_LEVEL;
        valid_next    = 1'b0;
        fault_next    = 1'b0;
        change_next   = 1'b0;
        case (state)
            ST_INIT: begin
                if (stab_cnt == STAB_MAX) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                    level_next = filt_next;
                    valid_next = 1'b1;
                end else begin
                    state_next = ST_INIT;
                    if (sync == prev_sync) begin
                        stab_cnt_next = stab_cnt + STAB_W'(1);
                    end
                end
            end
            ST_RUN: begin
                state_next  = ST_RUN;
                level_next  = filt_next;
                valid_next  = 1'b1;
                change_next = (filt_next != filt);
                if (filt == FAULT_CODE) begin
                    if (flt_cnt == FLT_MAX) begin
                        state_next  = ST_FAULT;
                        level_next  = SAFE_LEVEL;
                        valid_next  = 1'b0;
                        fault_next  = 1'b1;
                        change_next = 1'b0;
                    end else begin
                        flt_cnt_next = flt_cnt + FLT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                if (!(fault_clear && (filt != FAULT_CODE))) begin
                    state_next = ST_FAULT;
                    fault_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner with DEBOUNCE_CYCLES=4, FAULT_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_level_sensor_conditioner;

    logic       clock;
    logic       reset;
    logic [1:0] raw_sensors;
    logic       fault_clear;
    logic [1:0] level_sensors;
    logic       sensors_valid;
    logic       fault;
    logic       change_pulse;

    int checks = 0;
    int errors = 0;

    level_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .FAULT_CYCLES    (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .raw_sensors   (raw_sensors),
        .fault_clear   (fault_clear),
        .level_sensors (level_sensors),
        .sensors_valid (sensors_valid),
        .fault         (fault),
        .change_pulse  (change_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] lvl, input logic vld,
                              input logic flt, input logic chg);
        checks++;
        assert (level_sensors === lvl) else begin
            errors++;
            $error("FAIL %s level_sensors: observed %b expected %b", tag, level_sensors, lvl);
        end
        checks++;
        assert (sensors_valid === vld) else begin
            errors++;
            $error("FAIL %s sensors_valid: observed %b expected %b", tag, sensors_valid, vld);
        end
        checks++;
        assert (fault === flt) else begin
            errors++;
            $error("FAIL %s fault: observed %b expected %b", tag, fault, flt);
        end
        checks++;
        assert (change_pulse === chg) else begin
            errors++;
            $error("FAIL %s change_pulse: observed %b expected %b", tag, change_pulse, chg);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        raw_sensors = 2'b01;
        fault_clear = 1'b0;
        step(2);
        expect_out("reset", 2'b11, 1'b0, 1'b0, 1'b0);

        // Power-up: 2 sync edges, then the stability count; RUN on the 7th edge.
        reset = 1'b0;
        step(6);
        expect_out("init_hold", 2'b11, 1'b0, 1'b0, 1'b0);
        step(1);
        expect_out("init_to_run", 2'b01, 1'b1, 1'b0, 1'b0);

        // Step 01 -> 11: visible exactly 6 edges later with a single pulse.
        raw_sensors = 2'b11;
        step(5);
        expect_out("step_before", 2'b01, 1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("step_edge6", 2'b11, 1'b1, 1'b0, 1'b1);
        step(1);
        expect_out("step_after", 2'b11, 1'b1, 1'b0, 1'b0);

        // Both bits fall together.
        raw_sensors = 2'b00;
        step(6);
        expect_out("both_fall", 2'b00, 1'b1, 1'b0, 1'b1);
        step(1);
        expect_out("both_fall_after", 2'b00, 1'b1, 1'b0, 1'b0);

        // 3-cycle glitch is suppressed.
        raw_sensors = 2'b01;
        step(3);
        raw_sensors = 2'b00;
        for (int i = 0; i < 8; i++) begin
            expect_out("glitch3", 2'b00, 1'b1, 1'b0, 1'b0);
            step(1);
        end

        // 4-cycle pulse is accepted, then debounced back.
        raw_sensors = 2'b01;
        step(4);
        raw_sensors = 2'b00;
        step(1);
        expect_out("pulse4_before", 2'b00, 1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("pulse4_rise", 2'b01, 1'b1, 1'b0, 1'b1);
        step(3);
        expect_out("pulse4_hold", 2'b01, 1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("pulse4_fall", 2'b00, 1'b1, 1'b0, 1'b1);

        // Impossible code 10: shown for 8 edges, then fault.
        raw_sensors = 2'b10;
        step(6);
        expect_out("bad_code_seen", 2'b10, 1'b1, 1'b0, 1'b1);
        step(7);
        expect_out("fault_count7", 2'b10, 1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("fault_raised", 2'b11, 1'b0, 1'b1, 1'b0);

        // Clear refused while code is still 10.
        fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        expect_out("clear_refused", 2'b11, 1'b0, 1'b1, 1'b0);
        step(1);
        expect_out("fault_sticky", 2'b11, 1'b0, 1'b1, 1'b0);

        // Fix sensors, then clear: INIT for 4 edges, then RUN.
        raw_sensors = 2'b11;
        step(6);
        expect_out("fault_fixed_wait", 2'b11, 1'b0, 1'b1, 1'b0);
        fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        expect_out("clear_to_init", 2'b11, 1'b0, 1'b0, 1'b0);
        step(3);
        expect_out("reinit_hold", 2'b11, 1'b0, 1'b0, 1'b0);
        step(1);
        expect_out("reinit_run", 2'b11, 1'b1, 1'b0, 1'b0);

        // Reset two cycles into a debounce count.
        raw_sensors = 2'b00;
        step(4);
        reset = 1'b1;
        step(1);
        expect_out("reset_mid_debounce", 2'b11, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(3);
        expect_out("post_reset_init", 2'b11, 1'b0, 1'b0, 1'b0);
        step(1);
        expect_out("post_reset_run", 2'b00, 1'b1, 1'b0, 1'b0);

        // Reset part-way through a fault count; a full fresh count is needed afterwards.
        raw_sensors = 2'b10;
        step(6);
        expect_out("bad_code_again", 2'b10, 1'b1, 1'b0, 1'b1);
        step(4);
        reset = 1'b1;
        step(1);
        expect_out("reset_mid_fault", 2'b11, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(7);
        expect_out("refresh_run", 2'b10, 1'b1, 1'b0, 1'b0);
        step(7);
        expect_out("refresh_count7", 2'b10, 1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("refresh_fault", 2'b11, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
